// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: serves the control word's memory field (MEM_READ / MEM_WRITE)
// by running one complete single-byte frame to an external 23LC-style SPI SRAM
// in mode 0. It replaces on-chip memory between the address mux and MUX_MEM.
// The control unit stalls while BusyxSO is high.

package controlpack;
  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_op_e;
endpackage

module spi_mem_ctrl
  import controlpack::*;
#(
  parameter int ADDR_W  = 9,   // 1..16, zero-extended to the 16-bit SPI address
  parameter int CLK_DIV = 2    // system cycles per SCK half-period, >= 1
) (
  input  logic              ClkxCI,
  input  logic              RstxRI,
  input  logic [1:0]        MemOpxSI,
  input  logic [ADDR_W-1:0] AddrxDI,
  input  logic [7:0]        WrDataxDI,
  output logic [7:0]        RdDataxDO,
  output logic              BusyxSO,
  output logic              DonexSO,
  output logic              SpiCsnxSO,
  output logic              SpiSckxSO,
  output logic              SpiMosixDO,
  input  logic              SpiMisoxDI
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q;
  logic [30:0]      frame_q;    // bits still to be sent after the one on MOSI
  logic [7:0]       rx_q;       // most recent eight MISO samples
  logic [4:0]       bitCnt_q;
  logic [DIV_W-1:0] divCnt_q;
  logic             isRead_q;
  logic             csn_q;
  logic             sck_q;
  logic             mosi_q;
  logic             done_q;
  logic [7:0]       rdData_q;

  logic        rdReq;
  logic        wrReq;
  logic [31:0] newFrame;

  // Decode the request; encoding 3 matches neither and is treated as a NOP.
  assign rdReq    = (MemOpxSI == MEM_READ);
  assign wrReq    = (MemOpxSI == MEM_WRITE);
  assign newFrame = {rdReq ? 8'h03 : 8'h02, 16'(AddrxDI), rdReq ? 8'h00 : WrDataxDI};

  assign RdDataxDO  = rdData_q;
  assign BusyxSO    = (state_q != IDLE);
  assign DonexSO    = done_q;
  assign SpiCsnxSO  = csn_q;
  assign SpiSckxSO  = sck_q;
  assign SpiMosixDO = mosi_q;

  // Transaction FSM: accept in IDLE, clock out 32 bits in SHIFT, keep CSn low
  // for one extra half-period in HOLD, then complete with a DonexSO pulse.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      rx_q     <= '0;
      bitCnt_q <= '0;
      divCnt_q <= '0;
      isRead_q <= 1'b0;
      csn_q    <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      rdData_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rdReq || wrReq) begin
            state_q  <= SHIFT;
            frame_q  <= newFrame[30:0];
            mosi_q   <= newFrame[31];
            isRead_q <= rdReq;
            csn_q    <= 1'b0;
            sck_q    <= 1'b0;
            bitCnt_q <= '0;
            divCnt_q <= '0;
          end
        end
        SHIFT: begin
          if (divCnt_q == DIV_LAST) begin
            divCnt_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], SpiMisoxDI};
            end else begin
              sck_q    <= 1'b0;
              bitCnt_q <= bitCnt_q + 5'd1;
              frame_q  <= {frame_q[29:0], 1'b0};
              if (bitCnt_q == 5'd31) begin
                state_q <= HOLD;
                mosi_q  <= 1'b0;
              end else begin
                mosi_q <= frame_q[30];
              end
            end
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
        end
        HOLD: begin
          if (divCnt_q == DIV_LAST) begin
            divCnt_q <= '0;
            state_q  <= IDLE;
            csn_q    <= 1'b1;
            done_q   <= 1'b1;
            if (isRead_q) begin
              rdData_q <= rx_q;
            end
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: directed bench for spi_mem_ctrl. Instance A uses CLK_DIV=2,
// instance B uses CLK_DIV=1. A small SPI SRAM model returns a chosen byte on
// MISO during the data phase of each frame.

module tb_spi_mem_ctrl;
  import controlpack::*;

  logic       clk;
  logic       reset;
  logic [1:0] opA, opB;
  logic [8:0] addr;
  logic [7:0] wrData;
  logic       misoA, misoB;

  logic [7:0] rdA, rdB;
  logic       busyA, doneA, csnA, sckA, mosiA;
  logic       busyB, doneB, csnB, sckB, mosiB;

  int compared;
  int mismatched;

  // Observations gathered while a frame runs
  logic [31:0] obsMosi;
  int          obsRises, obsBusyCount, obsLastBusy, obsDoneCount, obsFirstDone;
  int          obsCsnLow, obsSckHigh, obsMaxHighRun;
  logic        obsCsnFirst;
  logic [7:0]  obsRdAtDone;

  spi_mem_ctrl #(.ADDR_W(9), .CLK_DIV(2)) dutA (
    .ClkxCI(clk), .RstxRI(reset), .MemOpxSI(opA), .AddrxDI(addr),
    .WrDataxDI(wrData), .RdDataxDO(rdA), .BusyxSO(busyA), .DonexSO(doneA),
    .SpiCsnxSO(csnA), .SpiSckxSO(sckA), .SpiMosixDO(mosiA), .SpiMisoxDI(misoA)
  );

  spi_mem_ctrl #(.ADDR_W(9), .CLK_DIV(1)) dutB (
    .ClkxCI(clk), .RstxRI(reset), .MemOpxSI(opB), .AddrxDI(addr),
    .WrDataxDI(wrData), .RdDataxDO(rdB), .BusyxSO(busyB), .DonexSO(doneB),
    .SpiCsnxSO(csnB), .SpiSckxSO(sckB), .SpiMosixDO(mosiB), .SpiMisoxDI(misoB)
  );

  // Free-running system clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents a request for one cycle (called just after a negedge), then steps
  // nCycles cycles sampling outputs on each negedge. Also plays the SRAM side:
  // after rise r has been seen, MISO carries the bit for rise r+1.
  task automatic applyStimulus(input int idx, input logic [1:0] opIn,
                               input logic [8:0] addrIn, input logic [7:0] wdIn,
                               input logic [7:0] misoByte, input int nCycles,
                               input int injCycle, input logic [1:0] injOp);
    logic       cs, sk, mo, bz, dn, prevSck, m;
    logic [7:0] rd;
    int         run;
    obsMosi = '0; obsRises = 0; obsBusyCount = 0; obsLastBusy = 0;
    obsDoneCount = 0; obsFirstDone = 0; obsCsnLow = 0; obsSckHigh = 0;
    obsMaxHighRun = 0; obsCsnFirst = 1'bx; obsRdAtDone = 'x;
    addr = addrIn;
    wrData = wdIn;
    if (idx == 0) opA = opIn; else opB = opIn;
    prevSck = 1'b0;
    run = 0;
    for (int k = 1; k <= nCycles; k++) begin
      @(negedge clk);
      if (idx == 0) begin
        cs = csnA; sk = sckA; mo = mosiA; bz = busyA; dn = doneA; rd = rdA;
      end else begin
        cs = csnB; sk = sckB; mo = mosiB; bz = busyB; dn = doneB; rd = rdB;
      end
      if (k == 1) obsCsnFirst = cs;
      if (!cs) obsCsnLow++;
      if (bz) begin
        obsBusyCount++;
        obsLastBusy = k;
      end
      if (dn) begin
        obsDoneCount++;
        if (obsFirstDone == 0) obsFirstDone = k;
        obsRdAtDone = rd;
      end
      if (sk) begin
        obsSckHigh++;
        run++;
        if (run > obsMaxHighRun) obsMaxHighRun = run;
      end else begin
        run = 0;
      end
      if (sk && !prevSck) begin
        obsRises++;
        obsMosi = {obsMosi[30:0], mo};
      end
      prevSck = sk;
      m = (obsRises >= 24 && obsRises < 32) ? misoByte[7 - (obsRises - 24)] : 1'b0;
      if (idx == 0) misoA = m; else misoB = m;
      if (idx == 0) opA = (k == injCycle) ? injOp : MEM_NOP;
      else          opB = (k == injCycle) ? injOp : MEM_NOP;
    end
  endtask

  // Reset held two cycles with a read request pending
  task automatic test_reset();
    reset = 1'b1; opA = MEM_READ; opB = MEM_READ;
    addr = 9'h1A5; wrData = 8'hFF; misoA = 1'b1; misoB = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compared++; if (csnA !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_csn: got %b want 1", csnA); end
      compared++; if (sckA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sck: got %b want 0", sckA); end
      compared++; if (mosiA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mosi: got %b want 0", mosiA); end
      compared++; if (busyA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
      compared++; if (doneA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", doneA); end
      compared++; if (rdA !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h want 00", rdA); end
      compared++; if (csnB !== 1'b1 || sckB !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_b_spi: got csn=%b sck=%b want csn=1 sck=0", csnB, sckB); end
    end
    reset = 1'b0; opA = MEM_NOP; opB = MEM_NOP; misoA = 1'b0; misoB = 1'b0;
  endtask

  // Read of 0x1A5 with the memory returning 0x5C
  task automatic test_read();
    applyStimulus(0, MEM_READ, 9'h1A5, 8'hEE, 8'h5C, 131, 0, MEM_NOP);
    compared++; if (obsMosi !== 32'h0301A500) begin mismatched++; $display("[TB] FAIL read_mosi: got %h want 0301a500", obsMosi); end
    compared++; if (obsRises !== 32) begin mismatched++; $display("[TB] FAIL read_sck_rises: got %0d want 32", obsRises); end
    compared++; if (obsBusyCount !== 130 || obsLastBusy !== 130) begin mismatched++; $display("[TB] FAIL read_busy: got count=%0d last=%0d want 130/130", obsBusyCount, obsLastBusy); end
    compared++; if (obsDoneCount !== 1 || obsFirstDone !== 131) begin mismatched++; $display("[TB] FAIL read_done: got count=%0d at=%0d want 1 at 131", obsDoneCount, obsFirstDone); end
    compared++; if (obsRdAtDone !== 8'h5C) begin mismatched++; $display("[TB] FAIL read_rdata: got %h want 5c", obsRdAtDone); end
    compared++; if (obsCsnLow !== 130) begin mismatched++; $display("[TB] FAIL read_csn_low: got %0d want 130", obsCsnLow); end
  endtask

  // Write 0x3C to 0x0FF; MISO noise must not disturb the held read byte
  task automatic test_write();
    applyStimulus(0, MEM_WRITE, 9'h0FF, 8'h3C, 8'hA7, 131, 0, MEM_NOP);
    compared++; if (obsMosi !== 32'h0200FF3C) begin mismatched++; $display("[TB] FAIL write_mosi: got %h want 0200ff3c", obsMosi); end
    compared++; if (obsRises !== 32) begin mismatched++; $display("[TB] FAIL write_sck_rises: got %0d want 32", obsRises); end
    compared++; if (obsDoneCount !== 1 || obsFirstDone !== 131) begin mismatched++; $display("[TB] FAIL write_done: got count=%0d at=%0d want 1 at 131", obsDoneCount, obsFirstDone); end
    compared++; if (obsRdAtDone !== 8'h5C) begin mismatched++; $display("[TB] FAIL write_rdata_kept: got %h want 5c", obsRdAtDone); end
    compared++; if (rdA !== 8'h5C) begin mismatched++; $display("[TB] FAIL write_rdata_after: got %h want 5c", rdA); end
  endtask

  // Read issued in the Done cycle of the previous read, plus a write pulsed mid-frame
  task automatic test_back_to_back();
    applyStimulus(0, MEM_READ, 9'h055, 8'h00, 8'h96, 131, 0, MEM_NOP);
    compared++; if (obsRdAtDone !== 8'h96 || obsFirstDone !== 131) begin mismatched++; $display("[TB] FAIL b2b_first: got rdata=%h done_at=%0d want 96 at 131", obsRdAtDone, obsFirstDone); end
    applyStimulus(0, MEM_READ, 9'h1FE, 8'h77, 8'h21, 131, 50, MEM_WRITE);
    compared++; if (obsCsnFirst !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_csn_gap: got csn=%b in cycle 1 want 0", obsCsnFirst); end
    compared++; if (obsMosi !== 32'h0301FE00) begin mismatched++; $display("[TB] FAIL b2b_mosi: got %h want 0301fe00", obsMosi); end
    compared++; if (obsDoneCount !== 1 || obsFirstDone !== 131) begin mismatched++; $display("[TB] FAIL b2b_done: got count=%0d at=%0d want 1 at 131", obsDoneCount, obsFirstDone); end
    compared++; if (obsRdAtDone !== 8'h21) begin mismatched++; $display("[TB] FAIL b2b_rdata: got %h want 21", obsRdAtDone); end
    applyStimulus(0, MEM_NOP, 9'h000, 8'h00, 8'h00, 140, 0, MEM_NOP);
    compared++; if (obsCsnLow !== 0 || obsRises !== 0 || obsDoneCount !== 0) begin mismatched++; $display("[TB] FAIL busy_ignored: got csn_low=%0d rises=%0d done=%0d want 0/0/0", obsCsnLow, obsRises, obsDoneCount); end
  endtask

  // Reset asserted during cycle 40 of a read
  task automatic test_reset_mid_frame();
    applyStimulus(0, MEM_READ, 9'h123, 8'h00, 8'hFF, 40, 0, MEM_NOP);
    reset = 1'b1;
    @(negedge clk);
    compared++; if (csnA !== 1'b1 || sckA !== 1'b0 || mosiA !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_spi: got csn=%b sck=%b mosi=%b want 1/0/0", csnA, sckA, mosiA); end
    compared++; if (busyA !== 1'b0 || doneA !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy_done: got busy=%b done=%b want 0/0", busyA, doneA); end
    compared++; if (rdA !== 8'h00) begin mismatched++; $display("[TB] FAIL midrst_rdata: got %h want 00", rdA); end
    reset = 1'b0;
    applyStimulus(0, MEM_NOP, 9'h000, 8'h00, 8'h00, 150, 0, MEM_NOP);
    compared++; if (obsDoneCount !== 0 || obsCsnLow !== 0) begin mismatched++; $display("[TB] FAIL midrst_no_done: got done=%0d csn_low=%0d want 0/0", obsDoneCount, obsCsnLow); end
  endtask

  // CLK_DIV=1 instance: op encoding 3 is a NOP, then a full read
  task automatic test_div1();
    applyStimulus(1, 2'b11, 9'h0A0, 8'h55, 8'h00, 70, 0, MEM_NOP);
    compared++; if (obsCsnLow !== 0 || obsRises !== 0 || obsBusyCount !== 0 || obsDoneCount !== 0) begin mismatched++; $display("[TB] FAIL div1_op3: got csn_low=%0d rises=%0d busy=%0d done=%0d want all 0", obsCsnLow, obsRises, obsBusyCount, obsDoneCount); end
    applyStimulus(1, MEM_READ, 9'h0A0, 8'h55, 8'hC3, 66, 0, MEM_NOP);
    compared++; if (obsMosi !== 32'h0300A000) begin mismatched++; $display("[TB] FAIL div1_mosi: got %h want 0300a000", obsMosi); end
    compared++; if (obsDoneCount !== 1 || obsFirstDone !== 66) begin mismatched++; $display("[TB] FAIL div1_done: got count=%0d at=%0d want 1 at 66", obsDoneCount, obsFirstDone); end
    compared++; if (obsRdAtDone !== 8'hC3) begin mismatched++; $display("[TB] FAIL div1_rdata: got %h want c3", obsRdAtDone); end
    compared++; if (obsRises !== 32 || obsSckHigh !== 32 || obsMaxHighRun !== 1) begin mismatched++; $display("[TB] FAIL div1_sck_period: got rises=%0d high=%0d maxrun=%0d want 32/32/1", obsRises, obsSckHigh, obsMaxHighRun); end
    compared++; if (obsBusyCount !== 65) begin mismatched++; $display("[TB] FAIL div1_busy: got %0d want 65", obsBusyCount); end
  endtask

  // Scenario sequence
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_frame();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
